// File: rtl/dpwm_pkg.sv
// Definitions shared by the dpwm gate generator and the dpwm_capture decoder,
// so both sides agree on counter widths and state encoding.
package dpwm_pkg;

    localparam int DPWM_W           = 12;
    localparam int DPWM_TIMEOUT     = 4095;
    localparam int DPWM_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_C1_ON = 3'd1,
        ST_DT2   = 3'd2,
        ST_C2_ON = 3'd3,
        ST_DT1   = 3'd4
    } cap_state_e;

endpackage

// File: rtl/sync_edge.sv
// N-stage synchroniser for one gate signal, followed by a registered level and
// rise/fall strobes that are all aligned to the same cycle.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic reset_n,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic s;
    logic lvl_q, rise_q, fall_q;

    generate
        if (STAGES == 0) begin : g_bypass
            assign s = d_i;
        end else begin : g_sync
            logic [STAGES-1:0] sync_q;
            always_ff @(posedge i_clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= d_i;
                    for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign s = sync_q[STAGES-1];
        end
    endgenerate

    // lvl_q is the one-cycle delayed copy; strobes are registered so that the
    // level and its edge strobe change on the same edge.
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            lvl_q  <= s;
            rise_q <= s & ~lvl_q;
            fall_q <= ~s & lvl_q;
        end
    end

    assign lvl_o  = lvl_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/dpwm_capture.sv
// Decodes the c1/c2 complementary gate pair into period, on-times and dead
// times, and flags shoot-through, illegal edge order and loss of switching.
module dpwm_capture
    import dpwm_pkg::*;
#(
    parameter int W           = DPWM_W,
    parameter int SYNC_STAGES = DPWM_SYNC_STAGES,
    parameter int TIMEOUT     = DPWM_TIMEOUT
) (
    input  logic         i_clk,
    input  logic         reset_n,
    input  logic         c1,
    input  logic         c2,
    input  logic         i_clr_err,
    output logic         o_valid,
    output logic [W-1:0] o_period,
    output logic [W-1:0] o_ton,
    output logic [W-1:0] o_tc2,
    output logic [W-1:0] o_dt1,
    output logic [W-1:0] o_dt2,
    output logic         o_locked,
    output logic         o_shoot,
    output logic         o_seq_err
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W-1:0] TO_VAL  = W'(TIMEOUT);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == CNT_MAX) ? v : v + ONE;
    endfunction

    logic s1, r1, f1, s2, r2, f2;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_c1 (
        .i_clk(i_clk), .reset_n(reset_n), .d_i(c1),
        .lvl_o(s1), .rise_o(r1), .fall_o(f1)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_c2 (
        .i_clk(i_clk), .reset_n(reset_n), .d_i(c2),
        .lvl_o(s2), .rise_o(r2), .fall_o(f2)
    );

    cap_state_e     state_q, state_d;
    logic [W-1:0]   per_q, per_d, ton_q, ton_d, tc2_q, tc2_d, dt1_q, dt1_d, dt2_q, dt2_d;
    logic [W-1:0]   out_per_q, out_per_d, out_ton_q, out_ton_d, out_tc2_q, out_tc2_d;
    logic [W-1:0]   out_dt1_q, out_dt1_d, out_dt2_q, out_dt2_d;
    logic           valid_q, valid_d, locked_q, locked_d;
    logic           shoot_q, shoot_d, seq_q, seq_d;
    logic           shoot_ev, seq_ev, restart, drop, complete;

    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        ton_d     = ton_q;
        tc2_d     = tc2_q;
        dt1_d     = dt1_q;
        dt2_d     = dt2_q;
        valid_d   = 1'b0;
        out_per_d = out_per_q;
        out_ton_d = out_ton_q;
        out_tc2_d = out_tc2_q;
        out_dt1_d = out_dt1_q;
        out_dt2_d = out_dt2_q;
        locked_d  = locked_q;
        shoot_ev  = s1 & s2;
        seq_ev    = 1'b0;
        restart   = 1'b0;
        drop      = 1'b0;
        complete  = 1'b0;

        if (state_q != ST_IDLE) per_d = sat_inc(per_q);

        // Priority: shoot-through, then timeout, then edge-order decoding.
        if (shoot_ev) begin
            drop = 1'b1;
        end else if (state_q != ST_IDLE && per_q >= TO_VAL) begin
            drop     = 1'b1;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: restart = r1;
                ST_C1_ON: begin
                    if (r2) begin
                        seq_ev = 1'b1;
                        drop   = 1'b1;
                    end else if (f1) begin
                        state_d = ST_DT2;
                        dt2_d   = ONE;
                    end else begin
                        ton_d = sat_inc(ton_q);
                    end
                end
                ST_DT2: begin
                    if (r1) begin
                        seq_ev  = 1'b1;
                        restart = 1'b1;
                    end else if (r2) begin
                        state_d = ST_C2_ON;
                        tc2_d   = ONE;
                    end else begin
                        dt2_d = sat_inc(dt2_q);
                    end
                end
                ST_C2_ON: begin
                    if (r1) begin
                        seq_ev  = 1'b1;
                        restart = 1'b1;
                    end else if (f2) begin
                        state_d = ST_DT1;
                        dt1_d   = ONE;
                    end else begin
                        tc2_d = sat_inc(tc2_q);
                    end
                end
                ST_DT1: begin
                    if (r2) begin
                        seq_ev = 1'b1;
                        drop   = 1'b1;
                    end else if (r1) begin
                        complete = 1'b1;
                        restart  = 1'b1;
                    end else begin
                        dt1_d = sat_inc(dt1_q);
                    end
                end
                default: drop = 1'b1;
            endcase
        end

        // The rise cycle itself is the first counted cycle of the new period.
        if (restart) begin
            state_d = ST_C1_ON;
            per_d   = ONE;
            ton_d   = ONE;
            tc2_d   = '0;
            dt1_d   = '0;
            dt2_d   = '0;
        end else if (drop) begin
            state_d = ST_IDLE;
            per_d   = '0;
            ton_d   = '0;
            tc2_d   = '0;
            dt1_d   = '0;
            dt2_d   = '0;
        end

        if (complete) begin
            valid_d   = 1'b1;
            locked_d  = 1'b1;
            out_per_d = per_q;
            out_ton_d = ton_q;
            out_tc2_d = tc2_q;
            out_dt1_d = dt1_q;
            out_dt2_d = dt2_q;
        end

        shoot_d = (shoot_q & ~i_clr_err) | shoot_ev;
        seq_d   = (seq_q & ~i_clr_err) | shoot_ev | seq_ev;
    end

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            per_q     <= '0;
            ton_q     <= '0;
            tc2_q     <= '0;
            dt1_q     <= '0;
            dt2_q     <= '0;
            valid_q   <= 1'b0;
            out_per_q <= '0;
            out_ton_q <= '0;
            out_tc2_q <= '0;
            out_dt1_q <= '0;
            out_dt2_q <= '0;
            locked_q  <= 1'b0;
            shoot_q   <= 1'b0;
            seq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            ton_q     <= ton_d;
            tc2_q     <= tc2_d;
            dt1_q     <= dt1_d;
            dt2_q     <= dt2_d;
            valid_q   <= valid_d;
            out_per_q <= out_per_d;
            out_ton_q <= out_ton_d;
            out_tc2_q <= out_tc2_d;
            out_dt1_q <= out_dt1_d;
            out_dt2_q <= out_dt2_d;
            locked_q  <= locked_d;
            shoot_q   <= shoot_d;
            seq_q     <= seq_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_period  = out_per_q;
    assign o_ton     = out_ton_q;
    assign o_tc2     = out_tc2_q;
    assign o_dt1     = out_dt1_q;
    assign o_dt2     = out_dt2_q;
    assign o_locked  = locked_q;
    assign o_shoot   = shoot_q;
    assign o_seq_err = seq_q;

endmodule
